// File: rtl/smi_read_arbiter.sv
// Two-requester SMI read arbiter: merges request frames onto one stream and routes in-order responses back.
// Define SMI_ARB_ROUND_ROBIN_EN for round-robin grants; by default port 0 has fixed priority.
// state     | meaning
// ArbIdle   | no frame in flight; choose a port and push its index into the route FIFO
// ArbLocked | granted port's flits pass through until its last flit transfers
module smi_read_arbiter #(
  parameter int DataWidth      = 128,
  parameter int RouteFifoDepth = 4,
  parameter int RouteIndexSize = 2
) (
  input  logic                 clk,
  input  logic                 srst,

  input  logic                 req0Ready,
  input  logic [7:0]           req0Eofc,
  input  logic [DataWidth-1:0] req0Data,
  output logic                 req0Stop,
  input  logic                 req1Ready,
  input  logic [7:0]           req1Eofc,
  input  logic [DataWidth-1:0] req1Data,
  output logic                 req1Stop,

  output logic                 reqOutReady,
  output logic [7:0]           reqOutEofc,
  output logic [DataWidth-1:0] reqOutData,
  input  logic                 reqOutStop,

  input  logic                 respInReady,
  input  logic [7:0]           respInEofc,
  input  logic [DataWidth-1:0] respInData,
  output logic                 respInStop,

  output logic                 resp0Ready,
  output logic [7:0]           resp0Eofc,
  output logic [DataWidth-1:0] resp0Data,
  input  logic                 resp0Stop,
  output logic                 resp1Ready,
  output logic [7:0]           resp1Eofc,
  output logic [DataWidth-1:0] resp1Data,
  input  logic                 resp1Stop
);

  typedef enum logic {
    ArbIdle   = 1'b0,
    ArbLocked = 1'b1
  } arb_state_t;

  localparam logic [RouteIndexSize-1:0] PtrOne    = RouteIndexSize'(1);
  localparam logic [RouteIndexSize:0]   CountOne  = (RouteIndexSize + 1)'(1);
  localparam logic [RouteIndexSize:0]   FullCount = (RouteIndexSize + 1)'(RouteFifoDepth);

  arb_state_t state, state_next;
  logic       grant, grant_next;
  logic       pick;
  logic       push, pop;

  logic                      route_mem [RouteFifoDepth];
  logic [RouteIndexSize-1:0] wr_ptr, rd_ptr;
  logic [RouteIndexSize:0]   count;
  logic                      fifo_full, fifo_empty, head;

  logic                 sel_ready;
  logic [7:0]           sel_eofc;
  logic [DataWidth-1:0] sel_data;
  logic                 resp_stop;

  assign fifo_full  = (count == FullCount);
  assign fifo_empty = (count == '0);
  assign head       = route_mem[rd_ptr];

`ifdef SMI_ARB_ROUND_ROBIN_EN
  logic last_grant;
  logic req_frame_end;

  // Prefer the port that did not win last time; fall back to whichever is ready.
  always_comb begin
    if (last_grant) pick = req0Ready ? 1'b0 : 1'b1;
    else            pick = req1Ready ? 1'b1 : 1'b0;
  end

  assign req_frame_end = (state == ArbLocked) && sel_ready && !reqOutStop && (sel_eofc != 8'd0);

  always_ff @(posedge clk) begin
    if (srst)               last_grant <= 1'b1;
    else if (req_frame_end) last_grant <= grant;
  end
`else
  always_comb begin
    pick = req0Ready ? 1'b0 : 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (srst) begin
      state <= ArbIdle;
      grant <= 1'b0;
    end else begin
      state <= state_next;
      grant <= grant_next;
    end
  end

  always_comb begin
    sel_ready = grant ? req1Ready : req0Ready;
    sel_eofc  = grant ? req1Eofc  : req0Eofc;
    sel_data  = grant ? req1Data  : req0Data;
  end

  always_comb begin
    state_next  = state;
    grant_next  = grant;
    push        = 1'b0;
    reqOutReady = 1'b0;
    reqOutEofc  = 8'd0;
    reqOutData  = '0;
    req0Stop    = 1'b1;
    req1Stop    = 1'b1;
    case (state)
      ArbIdle: begin
        if ((req0Ready || req1Ready) && !fifo_full) begin
          grant_next = pick;
          push       = 1'b1;
          state_next = ArbLocked;
        end
      end
      ArbLocked: begin
        reqOutReady = sel_ready;
        reqOutEofc  = sel_eofc;
        reqOutData  = sel_data;
        if (grant) req1Stop = reqOutStop;
        else       req0Stop = reqOutStop;
        if (sel_ready && !reqOutStop && (sel_eofc != 8'd0)) state_next = ArbIdle;
      end
      default: state_next = ArbIdle;
    endcase
  end

  // Responses follow the route FIFO head; nothing is accepted while no route is outstanding.
  assign resp0Eofc = respInEofc;
  assign resp0Data = respInData;
  assign resp1Eofc = respInEofc;
  assign resp1Data = respInData;

  always_comb begin
    resp0Ready = 1'b0;
    resp1Ready = 1'b0;
    resp_stop  = 1'b1;
    if (!fifo_empty) begin
      if (head) begin
        resp1Ready = respInReady;
        resp_stop  = resp1Stop;
      end else begin
        resp0Ready = respInReady;
        resp_stop  = resp0Stop;
      end
    end
  end

  assign respInStop = resp_stop;
  assign pop        = !fifo_empty && respInReady && !resp_stop && (respInEofc != 8'd0);

  always_ff @(posedge clk) begin
    if (push) route_mem[wr_ptr] <= grant_next;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PtrOne;
      if (pop)  rd_ptr <= rd_ptr + PtrOne;
      case ({push, pop})
        2'b10:   count <= count + CountOne;
        2'b01:   count <= count - CountOne;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_smi_read_arbiter.sv
// Scoreboard bench for smi_read_arbiter; expected request/response flits are queued as stimulus is driven.
// Expected grant order follows SMI_ARB_ROUND_ROBIN_EN the same way the design build does.
module tb_smi_read_arbiter;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          srst;
  logic          req0Ready, req1Ready;
  logic [7:0]    req0Eofc, req1Eofc;
  logic [DW-1:0] req0Data, req1Data;
  logic          req0Stop, req1Stop;
  logic          reqOutReady;
  logic [7:0]    reqOutEofc;
  logic [DW-1:0] reqOutData;
  logic          reqOutStop;
  logic          respInReady;
  logic [7:0]    respInEofc;
  logic [DW-1:0] respInData;
  logic          respInStop;
  logic          resp0Ready, resp1Ready;
  logic [7:0]    resp0Eofc, resp1Eofc;
  logic [DW-1:0] resp0Data, resp1Data;
  logic          resp0Stop, resp1Stop;

  always #5 clk = ~clk;

  smi_read_arbiter dut (
    .clk(clk), .srst(srst),
    .req0Ready(req0Ready), .req0Eofc(req0Eofc), .req0Data(req0Data), .req0Stop(req0Stop),
    .req1Ready(req1Ready), .req1Eofc(req1Eofc), .req1Data(req1Data), .req1Stop(req1Stop),
    .reqOutReady(reqOutReady), .reqOutEofc(reqOutEofc), .reqOutData(reqOutData), .reqOutStop(reqOutStop),
    .respInReady(respInReady), .respInEofc(respInEofc), .respInData(respInData), .respInStop(respInStop),
    .resp0Ready(resp0Ready), .resp0Eofc(resp0Eofc), .resp0Data(resp0Data), .resp0Stop(resp0Stop),
    .resp1Ready(resp1Ready), .resp1Eofc(resp1Eofc), .resp1Data(resp1Data), .resp1Stop(resp1Stop)
  );

  typedef struct {
    logic          port;
    logic [7:0]    eofc;
    logic [DW-1:0] data;
  } flit_t;

  flit_t req_q[$];
  flit_t resp_q[$];
  int    route_q[$];
  int    checks = 0;
  int    passed = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic mon_resp(input logic port, input logic [7:0] eofc, input logic [DW-1:0] data);
    flit_t e;
    if (resp_q.size() == 0) begin
      check("resp_extra", DW'(1), DW'(0));
    end else begin
      e = resp_q.pop_front();
      check("resp_port", DW'(port), DW'(e.port));
      check("resp_data", data, e.data);
      check("resp_eofc", DW'(eofc), DW'(e.eofc));
    end
  endtask

  always @(negedge clk) begin
    flit_t e;
    if (reqOutReady && !reqOutStop) begin
      if (req_q.size() == 0) begin
        check("req_extra", DW'(1), DW'(0));
      end else begin
        e = req_q.pop_front();
        check("req_data", reqOutData, e.data);
        check("req_eofc", DW'(reqOutEofc), DW'(e.eofc));
      end
    end
    if (resp0Ready && !resp0Stop) mon_resp(1'b0, resp0Eofc, resp0Data);
    if (resp1Ready && !resp1Stop) mon_resp(1'b1, resp1Eofc, resp1Data);
  end

  task automatic exp_req(input logic [DW-1:0] d, input logic [7:0] e);
    req_q.push_back('{1'b0, e, d});
  endtask

  // Returns at posedge+1 after the transfer; n counts negedges waited (1 = transferred at once).
  task automatic wait_xfer(input int p, input string tag, output int n);
    bit done = 1'b0;
    n = 0;
    while (!done) begin
      @(negedge clk);
      n++;
      case (p)
        0:       done = req0Ready && !req0Stop;
        1:       done = req1Ready && !req1Stop;
        default: done = respInReady && !respInStop;
      endcase
      if (!done && n >= 80) begin
        check({tag, "_timeout"}, DW'(0), DW'(1));
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_flit(input int p, input logic [DW-1:0] d, input logic [7:0] e, input string tag);
    int n;
    case (p)
      0: begin req0Ready = 1'b1; req0Data = d; req0Eofc = e; end
      1: begin req1Ready = 1'b1; req1Data = d; req1Eofc = e; end
      default: begin respInReady = 1'b1; respInData = d; respInEofc = e; end
    endcase
    wait_xfer(p, tag, n);
  endtask

  task automatic idle_port(input int p);
    case (p)
      0:       req0Ready = 1'b0;
      1:       req1Ready = 1'b0;
      default: respInReady = 1'b0;
    endcase
  endtask

  task automatic respond_all(input int nflits);
    while (route_q.size() > 0) begin
      int p;
      logic [DW-1:0] d;
      logic [7:0] e;
      p = route_q.pop_front();
      for (int i = 0; i < nflits; i++) begin
        d = rnd();
        e = (i == nflits - 1) ? 8'(i + 1) : 8'd0;
        resp_q.push_back('{1'(p), e, d});
        drive_flit(2, d, e, "resp");
      end
    end
    idle_port(2);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] d0[3];
    logic [DW-1:0] d1[3];
    logic [DW-1:0] r[3];
    int n;

    srst = 1'b1;
    req0Ready = 1'b0; req0Eofc = 8'd0; req0Data = '0;
    req1Ready = 1'b0; req1Eofc = 8'd0; req1Data = '0;
    reqOutStop = 1'b0;
    respInReady = 1'b0; respInEofc = 8'd0; respInData = '0;
    resp0Stop = 1'b0; resp1Stop = 1'b0;
    repeat (3) @(posedge clk);
    #1 srst = 1'b0;

    @(negedge clk);
    check("rst_reqOutReady", DW'(reqOutReady), DW'(0));
    check("rst_req0Stop", DW'(req0Stop), DW'(1));
    check("rst_req1Stop", DW'(req1Stop), DW'(1));
    check("rst_respInStop", DW'(respInStop), DW'(1));
    check("rst_resp0Ready", DW'(resp0Ready), DW'(0));
    check("rst_resp1Ready", DW'(resp1Ready), DW'(0));
    @(posedge clk); #1;

    // Both ports offer 1-flit frames back to back; four grants fill the route FIFO.
    for (int i = 0; i < 3; i++) begin d0[i] = rnd(); d1[i] = rnd(); end
`ifdef SMI_ARB_ROUND_ROBIN_EN
    exp_req(d0[0], 8'd1); exp_req(d1[0], 8'd1); exp_req(d0[1], 8'd1); exp_req(d1[1], 8'd1);
    route_q = '{0, 1, 0, 1};
`else
    exp_req(d0[0], 8'd1); exp_req(d0[1], 8'd1); exp_req(d1[0], 8'd1); exp_req(d1[1], 8'd1);
    route_q = '{0, 0, 1, 1};
`endif
    fork
      begin drive_flit(0, d0[0], 8'd1, "rr_p0a"); drive_flit(0, d0[1], 8'd1, "rr_p0b"); idle_port(0); end
      begin drive_flit(1, d1[0], 8'd1, "rr_p1a"); drive_flit(1, d1[1], 8'd1, "rr_p1b"); idle_port(1); end
    join

    // Fifth request must wait for the FIFO to drain.
    exp_req(d0[2], 8'd2);
    route_q.push_back(0);
    req0Ready = 1'b1; req0Data = d0[2]; req0Eofc = 8'd2;
    repeat (4) begin
      @(negedge clk);
      check("full_req0Stop", DW'(req0Stop), DW'(1));
      check("full_reqOutReady", DW'(reqOutReady), DW'(0));
    end
    @(posedge clk); #1;
    fork
      begin wait_xfer(0, "fifth", n); idle_port(0); end
      respond_all(2);
    join

    // Port 1 three-flit frame; port 0 becomes ready from flit 2 and must wait for the frame end.
    for (int i = 0; i < 3; i++) d1[i] = rnd();
    d0[0] = rnd();
    exp_req(d1[0], 8'd0); exp_req(d1[1], 8'd0); exp_req(d1[2], 8'd3); exp_req(d0[0], 8'd1);
    route_q.push_back(1);
    route_q.push_back(0);
    drive_flit(1, d1[0], 8'd0, "lock_f1");
    req0Ready = 1'b1; req0Data = d0[0]; req0Eofc = 8'd1;
    fork
      begin drive_flit(1, d1[1], 8'd0, "lock_f2"); drive_flit(1, d1[2], 8'd3, "lock_f3"); idle_port(1); end
      begin
        @(negedge clk); check("lock_req0Stop_f2", DW'(req0Stop), DW'(1));
        @(negedge clk); check("lock_req0Stop_f3", DW'(req0Stop), DW'(1));
      end
    join
    @(negedge clk);
    check("gap_idle", DW'(reqOutReady), DW'(0));
    wait_xfer(0, "after_gap", n);
    check("after_gap_cycles", DW'(n), DW'(1));
    idle_port(0);
    respond_all(1);

    // Downstream backpressure, then a stalled port-1 response.
    d1[0] = rnd();
    exp_req(d1[0], 8'd1);
    reqOutStop = 1'b1;
    req1Ready = 1'b1; req1Data = d1[0]; req1Eofc = 8'd1;
    repeat (3) @(negedge clk);
    check("outstop_req1Stop", DW'(req1Stop), DW'(1));
    check("outstop_reqOutReady", DW'(reqOutReady), DW'(1));
    @(posedge clk); #1;
    reqOutStop = 1'b0;
    wait_xfer(1, "outstop", n);
    idle_port(1);
    for (int i = 0; i < 3; i++) r[i] = rnd();
    resp_q.push_back('{1'b1, 8'd0, r[0]});
    resp_q.push_back('{1'b1, 8'd0, r[1]});
    resp_q.push_back('{1'b1, 8'd3, r[2]});
    resp1Stop = 1'b1;
    respInReady = 1'b1; respInData = r[0]; respInEofc = 8'd0;
    repeat (5) begin
      @(negedge clk);
      check("stall_respInStop", DW'(respInStop), DW'(1));
      check("stall_resp1Ready", DW'(resp1Ready), DW'(1));
    end
    @(posedge clk); #1;
    resp1Stop = 1'b0;
    wait_xfer(2, "stall_release", n);
    check("stall_release_cycles", DW'(n), DW'(1));
    drive_flit(2, r[1], 8'd0, "stall_f2");
    drive_flit(2, r[2], 8'd3, "stall_f3");
    idle_port(2);

    // Reset while flit 2 of a 3-flit frame is on the bus.
    d0[0] = rnd(); d0[1] = rnd();
    exp_req(d0[0], 8'd0); exp_req(d0[1], 8'd0);
    drive_flit(0, d0[0], 8'd0, "rst_f1");
    req0Data = d0[1];
    srst = 1'b1;
    @(posedge clk); #1;
    srst = 1'b0;
    req0Ready = 1'b0;
    @(negedge clk);
    check("midrst_reqOutReady", DW'(reqOutReady), DW'(0));
    check("midrst_req0Stop", DW'(req0Stop), DW'(1));
    check("midrst_respInStop", DW'(respInStop), DW'(1));
    @(posedge clk); #1;
    respInReady = 1'b1; respInData = rnd(); respInEofc = 8'd1;
    @(negedge clk);
    check("midrst_route_empty", DW'(respInStop), DW'(1));
    check("midrst_resp0Ready", DW'(resp0Ready), DW'(0));
    @(posedge clk); #1;
    respInReady = 1'b0;
    d0[2] = rnd();
    exp_req(d0[2], 8'd1);
    route_q.push_back(0);
    drive_flit(0, d0[2], 8'd1, "post_rst");
    idle_port(0);
    respond_all(1);

    repeat (3) @(posedge clk);
    check("req_q_empty", DW'(req_q.size()), DW'(0));
    check("resp_q_empty", DW'(resp_q.size()), DW'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
